word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial transmitter for the convolution multiplier datapath: accepts 16-bit result words over a valid/ready handshake and shifts them out one bit per enabled cycle with frame-valid and last-bit markers. It sits at the output of the result register stage and drives the bit-serial result link. A one-word hold buffer lets the next word be accepted while the current word shifts out, giving back-to-back frames with no gap.

## Interface
- WIDTH, 16, word width in bits (equals conv_pkg::WORD_W)
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  hold buffer can accept a word
- bit_en  input  1  bit-rate strobe; the serial side advances only on cycles where it is high
- ser_out  output  1  current serial bit
- ser_valid  output  1  a frame is in progress; ser_out is meaningful
- ser_last  output  1  ser_out is the final bit of the frame
- word_done  output  1  one-cycle pulse after the final bit is consumed

## Operation
- Reset: hold_full=0, state=IDLE, shift register=0, count=0; ser_out=0, ser_valid=0, ser_last=0, word_done=0, in_ready=1. Takes effect immediately, mid-frame included. A partial frame and any held word are discarded.
- in_ready = !hold_full. The handshake completes on an edge where in_valid && in_ready. in_data is captured into hold and hold_full is set.
- States (conv_pkg::ser_state_t): IDLE, SHIFT.
- IDLE with hold_full: on the next edge, hold moves to the shift register, count=0, state becomes SHIFT, and hold_full is cleared. bit_en is not required for this transfer.
- IDLE without hold_full: remains in IDLE. bit_en is ignored.
- SHIFT:
  - ser_valid=1.
  - ser_out is shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - ser_last = (count==WIDTH-1).
- SHIFT, on an edge with bit_en=1 and count<WIDTH-1: shift by one toward the output end, zero-fill, count++.
- SHIFT, on an edge with bit_en=1 and count==WIDTH-1:
  - word_done is asserted for one cycle.
  - If hold_full: load hold, count=0, stay in SHIFT, clear hold_full. This is a gapless back-to-back frame.
  - Otherwise: go to IDLE; ser_valid, ser_last and ser_out go to 0.
- SHIFT with bit_en=0: all state holds, and ser_out/ser_last are stable.
- Simultaneous accept and reload: not possible, because in_ready=0 while hold_full. in_ready rises the cycle after the hold word transfers.
- count width is $clog2(WIDTH). There is no wrap-around: count resets to 0 on every load.

## Timing
- Accept edge t0 with IDLE and empty hold:
  - Transfer at t0+1; ser_valid=1 and the first bit are visible after t0+1.
  - in_ready returns to 1 after t0+1.
- A frame occupies exactly WIDTH bit_en strobes. ser_last is high during the WIDTH-th bit.
- word_done is high for the cycle after the edge that consumes the last bit.
- Back-to-back: the first bit of the next word is presented on the cycle immediately after the last bit of the previous word, and ser_valid stays high.
- Outputs are all registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- conv_pkg: WORD_W=16 and the typedef enum ser_state_t {IDLE, SHIFT}.
- One sub-module, word_shifter: a loadable WIDTH-bit shift register with direction parameter, load, shift-enable and serial output. The FSM, hold buffer and counter stay in word_serializer.

## Test plan
- Reset, then send 16'hA5C3 with bit_en tied high:
  - ser_out sequence is 1010_0101_1100_0011.
  - ser_last is high only on the 16th bit.
  - word_done pulses once.
  - ser_valid falls after the 16th bit.
- MSB_FIRST=0, send 16'h0001 -> the first bit is 1 and the remaining 15 bits are 0.
- Send 16'hFFFF, then 16'h0000 immediately when in_ready rises:
  - 32 contiguous ser_valid cycles.
  - Exactly 16 ones followed by 16 zeros.
  - Two word_done pulses.
- bit_en high every 4th cycle, send 16'h8001:
  - The frame lasts 64 cycles.
  - ser_out is stable between strobes.
  - ser_last is held for 4 cycles.
- Assert rst after 7 bits of 16'h1234 with a second word held:
  - ser_valid=0 and in_ready=1 immediately.
  - No word_done pulse.
  - The next word sent after reset transmits correctly.
- Hold in_valid=1 while a frame shifts and hold is full -> in_ready stays 0 and no extra word is accepted (check by counting handshakes).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution multiplier datapath.
package conv_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/word_shifter.sv
// Loadable shift register that presents one end as a serial bit and zero-fills
// from the other end; MSB_FIRST selects which end faces the output.
module word_shifter #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_bit
);

    logic [WIDTH-1:0] shreg;

    // Load wins over shift so a reload on the final bit starts the new word intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    assign ser_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial result link transmitter: a one-word hold buffer feeds a
// shift register so consecutive words go out back to back with no idle bit.
module word_serializer
    import conv_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_bit;
    logic             load_hold;
    logic             shift_en;
    logic             sh_bit;

    // The final strobe of an unreloaded frame still shifts, leaving the register zeroed.
    always_comb begin
        accept    = in_valid && !hold_full;
        last_bit  = (state == SHIFT) && (count == LAST_CNT);
        load_hold = hold_full && ((state == IDLE) || (bit_en && last_bit));
        shift_en  = (state == SHIFT) && bit_en && !load_hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end else if (load_hold) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state <= SHIFT;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (!last_bit) begin
                            count <= count + 1'b1;
                        end else begin
                            word_done <= 1'b1;
                            count     <= '0;
                            if (!hold_full) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    word_shifter #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_hold),
        .shift_en (shift_en),
        .load_data(hold),
        .ser_bit  (sh_bit)
    );

    assign in_ready  = !hold_full;
    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid && sh_bit;
    assign ser_last  = last_bit;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an MSB-first and an LSB-first instance
// share clock, reset and bit strobe; a negedge monitor records the serial traffic.
module tb_word_serializer;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic bit_en;

    logic [15:0] in_data0, in_data1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic        ser_out0, ser_out1;
    logic        ser_valid0, ser_valid1;
    logic        ser_last0, ser_last1;
    logic        word_done0, word_done1;

    int tests = 0;
    int fails = 0;

    logic bits0[$];
    logic lasts0[$];
    logic bits1[$];
    int   valid_cnt0, segs0, last_cycles0, done_cnt0, hs0, stab_err, done_cnt1;
    logic prev_valid0 = 1'b0, prev_en = 1'b0, prev_out0 = 1'b0, prev_last0 = 1'b0;

    bit strobe_mode = 1'b0;
    int strobe_cnt  = 0;

    typedef struct {
        string       name;
        bit          lsb;
        logic [15:0] data;
        logic [15:0] exp_seq;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .bit_en(bit_en), .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_last(ser_last0),
        .word_done(word_done0)
    );

    word_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .bit_en(bit_en), .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_last(ser_last1),
        .word_done(word_done1)
    );

    // bit_en changes 2 time units after each rising edge, for use at the next edge.
    initial begin
        bit_en = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (strobe_mode) begin
                bit_en     = (strobe_cnt == 3);
                strobe_cnt = (strobe_cnt + 1) % 4;
            end else begin
                bit_en = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (ser_valid0) begin
            valid_cnt0++;
            if (!prev_valid0) segs0++;
            if (ser_last0) last_cycles0++;
            if (bit_en) begin
                bits0.push_back(ser_out0);
                lasts0.push_back(ser_last0);
            end
            if (prev_valid0 && !prev_en && (ser_out0 != prev_out0 || ser_last0 != prev_last0))
                stab_err++;
        end
        if (word_done0) done_cnt0++;
        if (in_valid0 && in_ready0) hs0++;
        if (ser_valid1 && bit_en) bits1.push_back(ser_out1);
        if (word_done1) done_cnt1++;
        prev_valid0 = ser_valid0;
        prev_en     = bit_en;
        prev_out0   = ser_out0;
        prev_last0  = ser_last0;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pack16(input logic q[$], input int start);
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            if (start + i < q.size()) r = {r[14:0], q[start+i]};
            else                      r = {r[14:0], 1'b0};
        end
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearTrace();
        bits0.delete();
        lasts0.delete();
        bits1.delete();
        valid_cnt0   = 0;
        segs0        = 0;
        last_cycles0 = 0;
        done_cnt0    = 0;
        hs0          = 0;
        stab_err     = 0;
        done_cnt1    = 0;
    endtask

    // Called 1 unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic applyStimulus(input bit which, input logic [15:0] d);
        bit got = 1'b0;
        if (!which) begin in_data0 = d; in_valid0 = 1'b1; end
        else        begin in_data1 = d; in_valid1 = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((!which && in_ready0) || (which && in_ready1)) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        if (!got) checkOutput("handshake_timeout", 0, 1);
    endtask

    task automatic waitDone(input bit which, input int target);
        for (int i = 0; i < 300; i++) begin
            if ((which ? done_cnt1 : done_cnt0) >= target) break;
            step(1);
        end
        if ((which ? done_cnt1 : done_cnt0) < target)
            checkOutput("done_timeout", which ? done_cnt1 : done_cnt0, target);
    endtask

    initial begin
        int ready_high;
        rst       = 1'b1;
        in_data0  = '0;
        in_data1  = '0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        clearTrace();

        vecs[0] = '{"a5c3_msb", 1'b0, 16'hA5C3, 16'b1010_0101_1100_0011};
        vecs[1] = '{"1234_msb", 1'b0, 16'h1234, 16'b0001_0010_0011_0100};
        vecs[2] = '{"0001_lsb", 1'b1, 16'h0001, 16'b1000_0000_0000_0000};
        vecs[3] = '{"a5c3_lsb", 1'b1, 16'hA5C3, 16'b1100_0011_1010_0101};
        vecs[4] = '{"0f0f_msb", 1'b0, 16'h0F0F, 16'b0000_1111_0000_1111};

        step(2);
        checkOutput("rst_ser_out",   int'(ser_out0),   0);
        checkOutput("rst_ser_valid", int'(ser_valid0), 0);
        checkOutput("rst_ser_last",  int'(ser_last0),  0);
        checkOutput("rst_word_done", int'(word_done0), 0);
        checkOutput("rst_in_ready",  int'(in_ready0),  1);
        rst = 1'b0;
        step(2);

        for (int v = 0; v < 5; v++) begin
            clearTrace();
            applyStimulus(vecs[v].lsb, vecs[v].data);
            waitDone(vecs[v].lsb, 1);
            step(3);
            if (vecs[v].lsb) begin
                checkOutput({vecs[v].name, "_nbits"}, bits1.size(), 16);
                checkOutput({vecs[v].name, "_seq"}, pack16(bits1, 0), int'(vecs[v].exp_seq));
                checkOutput({vecs[v].name, "_done"}, done_cnt1, 1);
                checkOutput({vecs[v].name, "_idle"}, int'(ser_valid1), 0);
            end else begin
                checkOutput({vecs[v].name, "_nbits"}, bits0.size(), 16);
                checkOutput({vecs[v].name, "_seq"}, pack16(bits0, 0), int'(vecs[v].exp_seq));
                checkOutput({vecs[v].name, "_last"}, pack16(lasts0, 0), 32'h0001);
                checkOutput({vecs[v].name, "_done"}, done_cnt0, 1);
                checkOutput({vecs[v].name, "_valid_cycles"}, valid_cnt0, 16);
                checkOutput({vecs[v].name, "_idle"}, int'(ser_valid0), 0);
            end
        end

        // Back-to-back frames with the second word loaded as soon as the hold frees.
        clearTrace();
        applyStimulus(1'b0, 16'hFFFF);
        applyStimulus(1'b0, 16'h0000);
        waitDone(1'b0, 2);
        step(3);
        checkOutput("b2b_valid_cycles", valid_cnt0, 32);
        checkOutput("b2b_segments", segs0, 1);
        checkOutput("b2b_nbits", bits0.size(), 32);
        checkOutput("b2b_first", pack16(bits0, 0), 32'hFFFF);
        checkOutput("b2b_second", pack16(bits0, 16), 32'h0000);
        checkOutput("b2b_done", done_cnt0, 2);
        checkOutput("b2b_last_cycles", last_cycles0, 2);

        // One strobe every fourth cycle, phased so the first bit is held four cycles.
        clearTrace();
        strobe_cnt  = 2;
        strobe_mode = 1'b1;
        applyStimulus(1'b0, 16'h8001);
        waitDone(1'b0, 1);
        step(3);
        strobe_mode = 1'b0;
        checkOutput("slow_valid_cycles", valid_cnt0, 64);
        checkOutput("slow_stability", stab_err, 0);
        checkOutput("slow_last_cycles", last_cycles0, 4);
        checkOutput("slow_nbits", bits0.size(), 16);
        checkOutput("slow_seq", pack16(bits0, 0), 32'h8001);
        checkOutput("slow_done", done_cnt0, 1);

        // Reset mid-frame with a second word waiting in the hold buffer.
        clearTrace();
        applyStimulus(1'b0, 16'h1234);
        applyStimulus(1'b0, 16'hABCD);
        for (int i = 0; i < 100; i++) begin
            if (bits0.size() >= 7) break;
            step(1);
        end
        checkOutput("rst_mid_bits_reached", int'(bits0.size() >= 7), 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_ser_valid", int'(ser_valid0), 0);
        checkOutput("rst_mid_in_ready", int'(in_ready0), 1);
        checkOutput("rst_mid_ser_out", int'(ser_out0), 0);
        checkOutput("rst_mid_ser_last", int'(ser_last0), 0);
        step(2);
        rst = 1'b0;
        step(20);
        checkOutput("rst_mid_no_done", done_cnt0, 0);
        checkOutput("rst_mid_hold_dropped", int'(ser_valid0), 0);
        clearTrace();
        applyStimulus(1'b0, 16'hBEEF);
        waitDone(1'b0, 1);
        step(3);
        checkOutput("post_rst_seq", pack16(bits0, 0), 32'hBEEF);
        checkOutput("post_rst_done", done_cnt0, 1);

        // in_valid held while the hold buffer is occupied must not be accepted.
        clearTrace();
        applyStimulus(1'b0, 16'h00FF);
        applyStimulus(1'b0, 16'hF00F);
        in_data0   = 16'h5555;
        in_valid0  = 1'b1;
        ready_high = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready0) ready_high++;
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        checkOutput("busy_ready_low", ready_high, 0);
        waitDone(1'b0, 2);
        step(3);
        checkOutput("busy_handshakes", hs0, 2);
        checkOutput("busy_done", done_cnt0, 2);
        checkOutput("busy_nbits", bits0.size(), 32);
        checkOutput("busy_first", pack16(bits0, 0), 32'h00FF);
        checkOutput("busy_second", pack16(bits0, 16), 32'hF00F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
